// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle.
// Groups the instruction-memory req/ack bus, the held-instruction outputs toward the
// control unit and the retire/next-PC inputs from the control unit and datapath.
//   master : the fetch unit (drives imem_req/imem_addr and the held-instruction outputs)
//   slave  : the surroundings (instruction memory, control unit, datapath)
interface fetch_unit_if;
  // Instruction memory request bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  // Held instruction toward the control unit
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opc;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  // Retire and next-PC selection
  logic        inst_taken;
  logic        jmp;
  logic        beq;
  logic        bne;
  logic        alu_zero;
  logic        inv_opcode;
  // Status
  logic        halted;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, opc, func, pc, pc_plus4, halted, retired,
    input  imem_ack, imem_data, inst_taken, jmp, beq, bne, alu_zero, inv_opcode
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, opc, func, pc, pc_plus4, halted, retired,
    output imem_ack, imem_data, inst_taken, jmp, beq, bne, alu_zero, inv_opcode
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS32 instruction fetch stage.
// Holds the PC, fetches one instruction per req/ack transaction, presents it with its
// opcode/function fields, and computes the next PC when the datapath retires it.
// An invalid opcode at retire stops fetch until reset.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, overrides every other input
//   bus  - fetch_unit_if.master: imem req/addr/ack/data, held instruction outputs
//          (inst_valid, inst, opc, func, pc, pc_plus4), retire controls
//          (inst_taken, jmp, beq, bne, alu_zero, inv_opcode), halted, retired count
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StHalt
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retired_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic        take_branch;
  logic [31:0] next_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign branch_off  = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign take_branch = (bus.beq & bus.alu_zero) | (bus.bne & ~bus.alu_zero);

  // Only consumed on a retire in StHold, so garbage on the controls elsewhere is harmless.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jmp) begin
      next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      retired_q <= 32'h0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StFetch: begin
          // Request and address stay put until the memory acks.
          if (bus.imem_ack) begin
            inst_q  <= bus.imem_data;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (bus.inst_taken) begin
            valid_q <= 1'b0;
            if (bus.inv_opcode) begin
              // pc and retired are frozen for debug.
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              pc_q      <= next_pc;
              retired_q <= retired_q + 32'd1;
              req_q     <= 1'b1;
              state_q   <= StFetch;
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.opc        = inst_q[31:26];
  assign bus.func       = inst_q[5:0];
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.halted     = halted_q;
  assign bus.retired    = retired_q;

endmodule
